// File: rtl/screen_fader.sv
// Frame-synchronous brightness fader: scales renderer RGB by a fade level that only
// changes on vsync ticks, and registers RGB together with the sync/blank strobes.
module screen_fader #(
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Red_in,
  input  logic [3:0] Green_in,
  input  logic [3:0] Blue_in,
  input  logic       hs,
  input  logic       vs,
  input  logic       active_nblank,
  input  logic       fade_out_req,
  input  logic       fade_in_req,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue,
  output logic       hs_out,
  output logic       vs_out,
  output logic       nblank_out,
  output logic [4:0] level,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] StShown   = 2'd0;
  localparam logic [1:0] StFadeOut = 2'd1;
  localparam logic [1:0] StHidden  = 2'd2;
  localparam logic [1:0] StFadeIn  = 2'd3;

  localparam logic [7:0] LastCnt = 8'(FRAMES_PER_STEP - 1);

  logic [1:0] state_q, state_d;
  logic [4:0] level_q, level_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       vs_q;
  logic       done_d;
  logic       tick;

  // A tick marks the leading (falling) edge of each active-low vsync pulse.
  assign tick = vs_q & ~vs;

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
    logic [7:0] prod;
    prod = 8'(c) * 8'(l);
    return 4'(prod >> 4);
  endfunction

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      StShown: begin
        if (fade_out_req) begin
          state_d     = StFadeOut;
          frame_cnt_d = 8'd0;
        end
      end
      StHidden: begin
        if (fade_in_req) begin
          state_d     = StFadeIn;
          frame_cnt_d = 8'd0;
        end
      end
      StFadeOut: begin
        if (tick) begin
          if (frame_cnt_q == LastCnt) begin
            frame_cnt_d = 8'd0;
            level_d     = level_q - 5'd1;
            if (level_q == 5'd1) begin
              state_d = StHidden;
              done_d  = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      StFadeIn: begin
        if (tick) begin
          if (frame_cnt_q == LastCnt) begin
            frame_cnt_d = 8'd0;
            level_d     = level_q + 5'd1;
            if (level_q == 5'd15) begin
              state_d = StShown;
              done_d  = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StShown;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StShown;
      level_q     <= 5'd16;
      frame_cnt_q <= 8'd0;
      vs_q        <= 1'b1;
      done        <= 1'b0;
      Red         <= 4'd0;
      Green       <= 4'd0;
      Blue        <= 4'd0;
      hs_out      <= 1'b1;
      vs_out      <= 1'b1;
      nblank_out  <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      vs_q        <= vs;
      done        <= done_d;
      // Scaling uses the registered level, so a step applies from the next pixel.
      Red         <= active_nblank ? scale(Red_in, level_q) : 4'd0;
      Green       <= active_nblank ? scale(Green_in, level_q) : 4'd0;
      Blue        <= active_nblank ? scale(Blue_in, level_q) : 4'd0;
      hs_out      <= hs;
      vs_out      <= vs;
      nblank_out  <= active_nblank;
    end
  end

  assign level = level_q;
  assign busy  = (state_q == StFadeOut) || (state_q == StFadeIn);

endmodule

// File: tb/tb_screen_fader.sv
// Randomized scoreboard bench for screen_fader: two instances (1 and 2 frames per step)
// share stimulus and are checked against a tick-counting reference model.
module tb_screen_fader;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] red_in, green_in, blue_in;
  logic       hs, vs, nblank, fout_req, fin_req;

  logic [3:0] red [2];
  logic [3:0] green [2];
  logic [3:0] blue [2];
  logic       hs_o [2];
  logic       vs_o [2];
  logic       nb_o [2];
  logic [4:0] lvl_o [2];
  logic       busy_o [2];
  logic       done_o [2];

  always #5 clk = ~clk;

  screen_fader #(.FRAMES_PER_STEP(1)) u_fast (
    .clk(clk), .reset(reset), .Red_in(red_in), .Green_in(green_in), .Blue_in(blue_in),
    .hs(hs), .vs(vs), .active_nblank(nblank), .fade_out_req(fout_req),
    .fade_in_req(fin_req), .Red(red[0]), .Green(green[0]), .Blue(blue[0]),
    .hs_out(hs_o[0]), .vs_out(vs_o[0]), .nblank_out(nb_o[0]), .level(lvl_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  screen_fader #(.FRAMES_PER_STEP(2)) u_slow (
    .clk(clk), .reset(reset), .Red_in(red_in), .Green_in(green_in), .Blue_in(blue_in),
    .hs(hs), .vs(vs), .active_nblank(nblank), .fade_out_req(fout_req),
    .fade_in_req(fin_req), .Red(red[1]), .Green(green[1]), .Blue(blue[1]),
    .hs_out(hs_o[1]), .vs_out(vs_o[1]), .nblank_out(nb_o[1]), .level(lvl_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  typedef struct {
    int r, g, b, hs, vs, nb, lvl, busy, done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;
  int dones = 0;

  // Model: 0 shown, 1 fading out, 2 hidden, 3 fading in; level derived from ticks seen.
  int fps [2] = '{1, 2};
  int m_mode [2];
  int m_ticks [2];
  int m_lvl [2];
  bit m_vs_prev;

  task automatic chk(input int k, input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL dut%0d %s actual=%0d required=%0d at %0t", k, name, act, req, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit   tick;
    tick = m_vs_prev && !vs;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_mode[k] = 0;
        m_lvl[k]  = 16;
        m_ticks[k] = 0;
        e = '{r: 0, g: 0, b: 0, hs: 1, vs: 1, nb: 0, lvl: 16, busy: 0, done: 0};
      end else begin
        e.r    = nblank ? (int'(red_in) * m_lvl[k]) / 16 : 0;
        e.g    = nblank ? (int'(green_in) * m_lvl[k]) / 16 : 0;
        e.b    = nblank ? (int'(blue_in) * m_lvl[k]) / 16 : 0;
        e.hs   = int'(hs);
        e.vs   = int'(vs);
        e.nb   = int'(nblank);
        e.done = 0;
        case (m_mode[k])
          0: if (fout_req) begin m_mode[k] = 1; m_ticks[k] = 0; end
          2: if (fin_req) begin m_mode[k] = 3; m_ticks[k] = 0; end
          1: if (tick) begin
            m_ticks[k]++;
            m_lvl[k] = 16 - m_ticks[k] / fps[k];
            if (m_lvl[k] == 0) begin m_mode[k] = 2; e.done = 1; end
          end
          default: if (tick) begin
            m_ticks[k]++;
            m_lvl[k] = m_ticks[k] / fps[k];
            if (m_lvl[k] == 16) begin m_mode[k] = 0; e.done = 1; end
          end
        endcase
        e.lvl  = m_lvl[k];
        e.busy = (m_mode[k] == 1 || m_mode[k] == 3) ? 1 : 0;
      end
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    m_vs_prev = reset ? 1'b1 : vs;
  endtask

  task automatic drive_next(input int c);
    reset    = (c < 3) || ($urandom_range(0, 1499) == 0);
    red_in   = 4'($urandom_range(0, 15));
    green_in = 4'($urandom_range(0, 15));
    blue_in  = 4'($urandom_range(0, 15));
    hs       = ($urandom_range(0, 3) != 0);
    vs       = 1'($urandom_range(0, 1));
    nblank   = ($urandom_range(0, 3) != 0);
    fout_req = ($urandom_range(0, 24) == 0);
    fin_req  = ($urandom_range(0, 24) == 0);
  endtask

  task automatic compare(input int k, input exp_t e);
    chk(k, "red", int'(red[k]), e.r);
    chk(k, "green", int'(green[k]), e.g);
    chk(k, "blue", int'(blue[k]), e.b);
    chk(k, "hs_out", int'(hs_o[k]), e.hs);
    chk(k, "vs_out", int'(vs_o[k]), e.vs);
    chk(k, "nblank_out", int'(nb_o[k]), e.nb);
    chk(k, "level", int'(lvl_o[k]), e.lvl);
    chk(k, "busy", int'(busy_o[k]), e.busy);
    chk(k, "done", int'(done_o[k]), e.done);
    if (e.done == 1) dones++;
  endtask

  // Monitor: outputs are valid every cycle; compare half a cycle after each edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, e);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    red_in   = 4'd0;
    green_in = 4'd0;
    blue_in  = 4'd0;
    hs       = 1'b1;
    vs       = 1'b1;
    nblank   = 1'b0;
    fout_req = 1'b0;
    fin_req  = 1'b0;
    m_vs_prev = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      model_step();
      #1;
      drive_next(c);
    end
    @(negedge clk);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d/%0d required=0/0", q0.size(), q1.size());
    end
    total++;
    if (dones < 4) begin
      bad++;
      $display("FAIL fade_completions actual=%0d required>=4", dones);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/screen_fader.md
# screen_fader

Frame-synchronous brightness fader between the poker screen renderers (start_screen and the table/card renderers) and the HDMI/VGA output encoder. Takes the 4-bit-per-channel RGB produced for the current drawX/drawY, plus the sync/blank strobes from vga_controller, and scales the colour by a fade level. The level only changes at frame boundaries, so screens fade out and in without tearing. It registers RGB and sync together so they stay aligned.

## Interface
- FRAMES_PER_STEP, default 2: frames held at each fade level; legal range 1..255. A full fade lasts 16*FRAMES_PER_STEP frames.
- clk  in  1  pixel clock; the same clock that drives vga_controller pixel_clk.
- reset  in  1  synchronous, active-high.
- Red_in, Green_in, Blue_in  in  4 each  colour from the screen renderer for the current pixel.
- hs, vs  in  1 each  from vga_controller, active low.
- active_nblank  in  1  from vga_controller; high means active video.
- fade_out_req  in  1  single-cycle request to fade to black.
- fade_in_req  in  1  single-cycle request to fade to full brightness.
- Red, Green, Blue  out  4 each  scaled colour, registered.
- hs_out, vs_out, nblank_out  out  1 each  hs, vs and active_nblank delayed by one cycle.
- level  out  5  current fade level, 0..16.
- busy  out  1  high while in FADE_OUT or FADE_IN.
- done  out  1  one-cycle pulse when a fade completes.

## Operation
- States:
  - SHOWN: level = 16.
  - FADE_OUT: level steps down.
  - HIDDEN: level = 0.
  - FADE_IN: level steps up.
- Frame tick: tick = vs_d & ~vs, where vs_d is vs registered one cycle. A tick marks the start of each vs pulse.
- Transitions:
  - SHOWN + fade_out_req → FADE_OUT.
  - HIDDEN + fade_in_req → FADE_IN.
  - Entering either fade state clears frame_cnt to 0.
- Stepping in a fade state, on each tick:
  - If frame_cnt == FRAMES_PER_STEP-1: clear frame_cnt and step level by 1.
  - Otherwise: increment frame_cnt.
- Fade completion:
  - FADE_OUT: when level steps to 0, go to HIDDEN and pulse done.
  - FADE_IN: when level steps to 16, go to SHOWN and pulse done.
- Requests that do not match the current stable state are ignored. This covers every request made during a fade, fade_in_req in SHOWN, and fade_out_req in HIDDEN.
- If fade_out_req and fade_in_req arrive in the same cycle, only the request matching the current state has any effect.
- Scaling, per channel: out = (in * level)[7:4].
  - The product is 8 bits wide; the maximum is 15*16 = 240.
  - level 16 returns the input exactly; level 0 returns 0.
- Blanking: when active_nblank = 0, the registered RGB is 0 regardless of level.
- frame_cnt is 8 bits wide. It never wraps, because it clears at FRAMES_PER_STEP-1.

## Timing
- Reset values:
  - state SHOWN, level 16, frame_cnt 0, vs_d 1.
  - Red/Green/Blue 0, hs_out/vs_out 1, nblank_out 0.
  - busy 0, done 0.
- RGB and sync latency: inputs sampled at edge t appear on the outputs after edge t. RGB and sync outputs have identical latency of 1 cycle.
- Request at edge t: state and busy change at edge t. The first level step happens at the FRAMES_PER_STEP-th tick after that.
- Level update: level changes on the same edge as the tick that triggers the step. Scaling uses the current level registered value, so a new level applies from the next pixel onward. That pixel is inside vsync blanking, so no visible mid-frame change occurs.
- done is registered. It is high for exactly the one cycle after the final-step edge, together with the state change. busy falls on that same edge.
- Reset mid-fade: on the next edge, return to the reset values above (SHOWN, level 16). No done pulse is generated.
- Holding vs low produces no extra ticks; a tick requires a 1→0 transition.

## Test plan
- Reset then release, with input F/F/F and active_nblank = 1 → after 1 cycle, output F/F/F, level 16, busy 0. With active_nblank = 0 → output 0/0/0.
- FRAMES_PER_STEP = 1, fade_out_req pulse, then 16 vs falling edges → level 15,14,…,0, one step per tick. With Red_in = F at level 8, Red = 7. After the 16th tick: state HIDDEN, done high for exactly 1 cycle, outputs 0.
- From HIDDEN with FRAMES_PER_STEP = 2, fade_in_req → level stays 0 after 1 tick, becomes 1 after 2 ticks, reaches 16 after 32 ticks. Then done pulses and a later Green_in = A gives Green = A.
- Requests during a fade: fade_in_req and fade_out_req pulses injected mid FADE_OUT → level sequence unchanged. fade_in_req while SHOWN and both requests together in SHOWN → only the fade-out starts.
- Reset asserted at level 9 in FADE_OUT → next cycle: level 16, busy 0, done 0, hs_out/vs_out 1.
- Alignment check: a random hs/vs/active_nblank pattern → hs_out/vs_out/nblank_out equal the inputs delayed by exactly 1 cycle, with RGB aligned to nblank_out.
